// File: rtl/fabric_config_pkg.sv
// Shared definitions for the fabric configuration loader.
// Contents: FSM state encoding, default sync/desync words, and address word field positions.
package fabric_config_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT   = 32'hFAB0FAB1;
    localparam logic [WORD_W-1:0] DESYNC_WORD_DEFAULT = 32'hFAB0FAB0;

    // Address word layout: [31:24] column, [23:5] reserved, [4:0] frame index
    localparam int unsigned COL_MSB   = 31;
    localparam int unsigned COL_LSB   = 24;
    localparam int unsigned COL_W     = COL_MSB - COL_LSB + 1;
    localparam int unsigned FRAME_MSB = 4;
    localparam int unsigned FRAME_LSB = 0;
    localparam int unsigned FRAME_W   = FRAME_MSB - FRAME_LSB + 1;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETUP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_STROBE = 3'd4;
    localparam logic [STATE_W-1:0] ST_HOLD   = 3'd5;

    // States in which a bitstream word can be accepted
    function automatic logic state_accepts(input logic [STATE_W-1:0] st);
        return (st == ST_IDLE) || (st == ST_ADDR) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/config_onehot_decoder.sv
// One-hot decoder for configuration enables.
// Ports: index_i (binary index), en_i (enable), onehot_c_o (combinational one-hot,
//        all zero when disabled or when index_i >= OUT_W).
module config_onehot_decoder #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IDX_W-1:0] index_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] onehot_c_o
);

    // Compare against every legal position; out-of-range indices match none
    always_comb begin
        onehot_c_o = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            onehot_c_o[i] = en_i && (32'(index_i) == i);
        end
    end

endmodule

// File: rtl/config_frame_loader.sv
// Configuration frame loader: hunts for the sync word, decodes address/data pairs,
// and sequences SETUP / STROBE / HOLD around the configuration latch enables.
// Ports: CLK, RESET (sync, active-high); WriteData/WriteStrobe bitstream input;
//        Ready (word accepted this cycle when high); FrameData latch data bus;
//        ColSelect / FrameStrobe one-hot latch enables; ConfigActive;
//        AddrError / Overrun sticky error flags. All outputs are registered.
module config_frame_loader
    import fabric_config_pkg::*;
#(
    parameter int unsigned       FRAME_BITS    = 32,
    parameter int unsigned       MAX_FRAMES    = 20,
    parameter int unsigned       NUM_COLUMNS   = 16,
    parameter int unsigned       STROBE_CYCLES = 2,
    parameter logic [WORD_W-1:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter logic [WORD_W-1:0] DESYNC_WORD   = DESYNC_WORD_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [WORD_W-1:0]      WriteData,
    input  logic                   WriteStrobe,
    output logic                   Ready,
    output logic [FRAME_BITS-1:0]  FrameData,
    output logic [NUM_COLUMNS-1:0] ColSelect,
    output logic [MAX_FRAMES-1:0]  FrameStrobe,
    output logic                   ConfigActive,
    output logic                   AddrError,
    output logic                   Overrun
);

    localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    logic [STATE_W-1:0]     state_q,     state_d;
    logic                   ready_q,     ready_d;
    logic [FRAME_BITS-1:0]  fdata_q,     fdata_d;
    logic [NUM_COLUMNS-1:0] col_sel_q,   col_sel_d;
    logic [MAX_FRAMES-1:0]  frame_stb_q, frame_stb_d;
    logic                   active_q,    active_d;
    logic                   addr_err_q,  addr_err_d;
    logic                   overrun_q,   overrun_d;
    logic [COL_W-1:0]       col_q,       col_d;
    logic [FRAME_W-1:0]     frame_q,     frame_d;
    logic                   addr_ok_q,   addr_ok_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;

    logic                   accept_c;
    logic                   strobe_en_c;
    logic [COL_W-1:0]       col_field_c;
    logic [FRAME_W-1:0]     frame_field_c;
    logic                   field_ok_c;

    assign col_field_c   = WriteData[COL_MSB:COL_LSB];
    assign frame_field_c = WriteData[FRAME_MSB:FRAME_LSB];
    assign field_ok_c    = (32'(col_field_c) < NUM_COLUMNS) && (32'(frame_field_c) < MAX_FRAMES);

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            fdata_q     <= '0;
            col_sel_q   <= '0;
            frame_stb_q <= '0;
            active_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            col_q       <= '0;
            frame_q     <= '0;
            addr_ok_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            fdata_q     <= fdata_d;
            col_sel_q   <= col_sel_d;
            frame_stb_q <= frame_stb_d;
            active_q    <= active_d;
            addr_err_q  <= addr_err_d;
            overrun_q   <= overrun_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            addr_ok_q   <= addr_ok_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        fdata_d    = fdata_q;
        active_d   = active_q;
        addr_err_d = addr_err_q;
        overrun_d  = overrun_q;
        col_d      = col_q;
        frame_d    = frame_q;
        addr_ok_d  = addr_ok_q;
        cnt_d      = cnt_q;

        accept_c = WriteStrobe && ready_q;
        // A word offered while not ready is dropped without touching the FSM
        if (WriteStrobe && !ready_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c && (WriteData == SYNC_WORD)) begin
                    state_d  = ST_ADDR;
                    active_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (accept_c) begin
                    if (WriteData == DESYNC_WORD) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end else if (WriteData != SYNC_WORD) begin
                        col_d      = col_field_c;
                        frame_d    = frame_field_c;
                        addr_ok_d  = field_ok_c;
                        addr_err_d = addr_err_q || !field_ok_c;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    fdata_d = FRAME_BITS'(WriteData);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_ADDR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d     = state_accepts(state_d);
        // Enables are registered, so they are computed from the state being entered
        strobe_en_c = (state_d == ST_STROBE) && addr_ok_q;
    end

    config_onehot_decoder #(
        .IDX_W (COL_W),
        .OUT_W (NUM_COLUMNS)
    ) u_col_dec (
        .index_i    (col_q),
        .en_i       (strobe_en_c),
        .onehot_c_o (col_sel_d)
    );

    config_onehot_decoder #(
        .IDX_W (FRAME_W),
        .OUT_W (MAX_FRAMES)
    ) u_frame_dec (
        .index_i    (frame_q),
        .en_i       (strobe_en_c),
        .onehot_c_o (frame_stb_d)
    );

    assign Ready        = ready_q;
    assign FrameData    = fdata_q;
    assign ColSelect    = col_sel_q;
    assign FrameStrobe  = frame_stb_q;
    assign ConfigActive = active_q;
    assign AddrError    = addr_err_q;
    assign Overrun      = overrun_q;

endmodule
